// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   mem_state_t : responder FSM states
//   mem_size_t  : access size encoding carried on the Size port
//   byte_en()   : byte-lane write mask for a given size and address LSBs
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_RSVD
  } mem_size_t;

  // Lane 0 is the least significant byte of the word.
  function automatic logic [3:0] byte_en(input mem_size_t size, input logic [1:0] addr_lo);
    logic [3:0] en;
    en = 4'b0000;
    case (size)
      SZ_BYTE: en = 4'b0001 << addr_lo;
      SZ_HALF: en = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 32-bit words split into four byte lanes.
//   clk   : clock
//   addr  : word index
//   we    : per-byte write enable (bit i writes wdata[8i+7:8i])
//   wdata : write data
//   rdata : registered read data (read-before-write), one cycle after addr
// No reset: contents and the read register are left as they are.
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One narrow array per lane keeps each lane a plain inferable RAM.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_rd_reg;

    always_ff @(posedge clk) begin
      if (we[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
      lane_rd_reg <= lane_mem[addr];
    end

    assign rdata[gi*8 +: 8] = lane_rd_reg;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the processor MEM stage.
// Accepts one load or store at a time, inserts WAIT_STATES extra cycles,
// then pulses Ready (with Error for rejected accesses).
//   Clock      : clock, rising edge
//   nReset     : asynchronous active-low reset
//   MemRead    : load request, held until Ready
//   MemWrite   : store request, held until Ready
//   MemAddr    : byte address
//   MemDataIn  : store data (byte/half from LSBs)
//   Size       : 00 byte, 01 half, 10 word, 11 reserved
//   SignExt    : sign-extend sub-word loads
//   MemDataOut : load data, valid while Ready
//   Ready      : one-cycle completion pulse
//   Stall      : request pending and not yet complete
//   Error      : one-cycle pulse for a rejected request
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemAddr,
  input  logic [31:0] MemDataIn,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  output logic [31:0] MemDataOut,
  output logic        Ready,
  output logic        Stall,
  output logic        Error
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_t  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  mem_size_t   size_reg;
  logic        sext_reg;
  logic        write_reg;

  logic        request;
  logic        conflict;
  logic        accept;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  mem_size_t   cur_size;
  logic        cur_write;
  logic        cur_err;
  logic        done_err;
  logic        do_access;

  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [31:0]   byte_shift;
  logic [31:0]   half_shift;

  function automatic logic access_error(input logic [31:0] addr, input mem_size_t size);
    logic bad;
    bad = 1'b0;
    if (size == SZ_RSVD) bad = 1'b1;
    if (size == SZ_HALF && addr[0]) bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
    if ((addr >> (AW + 2)) != 32'd0) bad = 1'b1;
    return bad;
  endfunction

  assign request  = MemRead ^ MemWrite;
  assign conflict = MemRead & MemWrite;
  assign accept   = (state_reg == IDLE) && request;

  // With zero wait states the RAM is accessed on the accept edge itself,
  // so the live request fields drive the RAM while idle.
  assign cur_addr  = (state_reg == IDLE) ? MemAddr : addr_reg;
  assign cur_data  = (state_reg == IDLE) ? MemDataIn : data_reg;
  assign cur_size  = (state_reg == IDLE) ? mem_size_t'(Size) : size_reg;
  assign cur_write = (state_reg == IDLE) ? MemWrite : write_reg;
  assign cur_err   = access_error(cur_addr, cur_size);
  assign done_err  = access_error(addr_reg, size_reg);

  // nReset gating stops a write from landing while reset is held.
  assign do_access = nReset &&
                     ((accept && (WAIT_STATES == 0)) ||
                      ((state_reg == BUSY) && (cnt_reg == 4'd0)));

  assign ram_addr = cur_addr[AW+1:2];
  assign ram_we   = (do_access && cur_write && !cur_err) ? byte_en(cur_size, cur_addr[1:0]) : 4'b0000;

  always_comb begin
    ram_wdata = cur_data;
    case (cur_size)
      SZ_BYTE: ram_wdata = {4{cur_data[7:0]}};
      SZ_HALF: ram_wdata = {2{cur_data[15:0]}};
      default: ram_wdata = cur_data;
    endcase
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem_array (
    .clk   (Clock),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // FSM state and wait counter
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (request) begin
          if (WAIT_STATES == 0) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latched request copy; the access completes from this even if the
  // pipeline drops its request early.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      size_reg  <= SZ_BYTE;
      sext_reg  <= 1'b0;
      write_reg <= 1'b0;
    end else if (accept) begin
      addr_reg  <= MemAddr;
      data_reg  <= MemDataIn;
      size_reg  <= mem_size_t'(Size);
      sext_reg  <= SignExt;
      write_reg <= MemWrite;
    end
  end

  assign byte_shift = ram_rdata >> {addr_reg[1:0], 3'b000};
  assign half_shift = ram_rdata >> {addr_reg[1], 4'b0000};

  always_comb begin
    MemDataOut = 32'd0;
    if (state_reg == DONE && !write_reg && !done_err) begin
      case (size_reg)
        SZ_BYTE: MemDataOut = {{24{sext_reg & byte_shift[7]}}, byte_shift[7:0]};
        SZ_HALF: MemDataOut = {{16{sext_reg & half_shift[15]}}, half_shift[15:0]};
        default: MemDataOut = ram_rdata;
      endcase
    end
  end

  assign Ready = (state_reg == DONE);
  assign Stall = nReset && (accept || (state_reg == BUSY));
  assign Error = nReset && (((state_reg == DONE) && done_err) ||
                            ((state_reg == IDLE) && conflict));

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WAIT_STATES=1
  logic        a_read = 0, a_write = 0, a_sext = 0;
  logic [31:0] a_addr = 0, a_din = 0;
  logic [1:0]  a_size = 0;
  logic [31:0] a_dout;
  logic        a_ready, a_stall, a_error;

  // Instance B: WAIT_STATES=0
  logic        b_read = 0, b_write = 0, b_sext = 0;
  logic [31:0] b_addr = 0, b_din = 0;
  logic [1:0]  b_size = 0;
  logic [31:0] b_dout;
  logic        b_ready, b_stall, b_error;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(1)) u_dut_a (
    .Clock(clk), .nReset(n_reset), .MemRead(a_read), .MemWrite(a_write),
    .MemAddr(a_addr), .MemDataIn(a_din), .Size(a_size), .SignExt(a_sext),
    .MemDataOut(a_dout), .Ready(a_ready), .Stall(a_stall), .Error(a_error)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_b (
    .Clock(clk), .nReset(n_reset), .MemRead(b_read), .MemWrite(b_write),
    .MemAddr(b_addr), .MemDataIn(b_din), .Size(b_size), .SignExt(b_sext),
    .MemDataOut(b_dout), .Ready(b_ready), .Stall(b_stall), .Error(b_error)
  );

  // Called just after a negedge. Holds the request until Ready, counts
  // Stall cycles before Ready, returns on the negedge after Ready.
  task automatic access(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size, input bit sext,
                        output logic [31:0] rdata, output logic err,
                        output int stalls, output bit done);
    if (sel) begin
      b_read = !wr; b_write = wr; b_addr = addr; b_din = data; b_size = size; b_sext = sext;
    end else begin
      a_read = !wr; a_write = wr; a_addr = addr; a_din = data; a_size = size; a_sext = sext;
    end
    done = 0; stalls = 0; rdata = '0; err = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (sel ? b_ready : a_ready) begin
        done  = 1;
        rdata = sel ? b_dout : a_dout;
        err   = sel ? b_error : a_error;
      end else if (sel ? b_stall : a_stall) begin
        stalls++;
      end
      @(negedge clk);
    end
    a_read = 0; a_write = 0; b_read = 0; b_write = 0;
    $display("access inst=%0d wr=%0d addr=%h size=%0d data=%h -> dout=%h err=%0d stalls=%0d done=%0d",
             sel, wr, addr, size, data, rdata, err, stalls, done);
  endtask

  task automatic test_reset();
    a_read = 1; a_addr = 32'h10; a_size = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", a_ready); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", a_error); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
    checks++; if (a_dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", a_dout); end
    a_read = 0;
    @(negedge clk);
    n_reset = 1;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int s; bit ok;
    access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok) begin errors++; $display("FAIL word_store_done: got timeout expected Ready"); end
    checks++; if (s != 2) begin errors++; $display("FAIL word_store_stall: got %0d expected 2", s); end
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b expected 0", a_ready); end
    @(negedge clk);
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok || d !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load: got %h expected deadbeef", d); end
    checks++; if (s != 2) begin errors++; $display("FAIL word_load_latency: got %0d expected 2", s); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_load_err: got %b expected 0", e); end
  endtask

  task automatic test_byte_store();
    logic [31:0] d; logic e; int s; bit ok;
    access(0, 1, 32'h10, 32'h11223344, 2'b10, 0, d, e, s, ok);
    access(0, 1, 32'h13, 32'h000000AB, 2'b00, 0, d, e, s, ok);
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok || d !== 32'hAB223344) begin errors++; $display("FAIL byte_store: got %h expected ab223344", d); end
    access(0, 1, 32'h12, 32'h0000BEEF, 2'b01, 0, d, e, s, ok);
    access(0, 0, 32'h10, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok || d !== 32'hBEEF3344) begin errors++; $display("FAIL half_store: got %h expected beef3344", d); end
  endtask

  task automatic test_subword();
    logic [31:0] d; logic e; int s; bit ok;
    access(0, 1, 32'h20, 32'h80F07F01, 2'b10, 0, d, e, s, ok);
    access(0, 0, 32'h20, 32'h0, 2'b00, 1, d, e, s, ok);
    checks++; if (!ok || d !== 32'h00000001) begin errors++; $display("FAIL byte0_sext: got %h expected 00000001", d); end
    access(0, 0, 32'h23, 32'h0, 2'b00, 1, d, e, s, ok);
    checks++; if (!ok || d !== 32'hFFFFFF80) begin errors++; $display("FAIL byte3_sext: got %h expected ffffff80", d); end
    access(0, 0, 32'h23, 32'h0, 2'b00, 0, d, e, s, ok);
    checks++; if (!ok || d !== 32'h00000080) begin errors++; $display("FAIL byte3_zext: got %h expected 00000080", d); end
    access(0, 0, 32'h22, 32'h0, 2'b01, 0, d, e, s, ok);
    checks++; if (!ok || d !== 32'h000080F0) begin errors++; $display("FAIL half2_zext: got %h expected 000080f0", d); end
    access(0, 0, 32'h20, 32'h0, 2'b01, 1, d, e, s, ok);
    checks++; if (!ok || d !== 32'h00007F01) begin errors++; $display("FAIL half0_sext: got %h expected 00007f01", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int s; bit ok;
    access(0, 0, 32'h12, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok || e !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b expected 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL misaligned_data: got %h expected 0", d); end
    checks++; if (s != 2) begin errors++; $display("FAIL misaligned_latency: got %0d expected 2", s); end
    access(0, 0, 32'h21, 32'h0, 2'b01, 0, d, e, s, ok);
    checks++; if (!ok || e !== 1'b1) begin errors++; $display("FAIL half_misaligned_err: got %b expected 1", e); end
    access(0, 0, 32'h24, 32'h0, 2'b11, 0, d, e, s, ok);
    checks++; if (!ok || e !== 1'b1) begin errors++; $display("FAIL rsvd_size_err: got %b expected 1", e); end
    access(0, 1, 32'h0, 32'h0BADC0DE, 2'b10, 0, d, e, s, ok);
    access(0, 1, 32'h1000, 32'hCAFEF00D, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok || e !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", e); end
    access(0, 0, 32'h0, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (d !== 32'h0BADC0DE || e !== 1'b0) begin errors++; $display("FAIL range_no_write: got %h expected 0badc0de", d); end
    access(0, 1, 32'h14, 32'h5A5A5A5A, 2'b10, 0, d, e, s, ok);
    access(0, 1, 32'h16, 32'h0000FFFF, 2'b01, 1, d, e, s, ok);
    access(0, 0, 32'h14, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (d !== 32'hFFFF5A5A) begin errors++; $display("FAIL half_store_hi: got %h expected ffff5a5a", d); end
    // Read and write together: rejected every cycle, never accepted
    a_read = 1; a_write = 1; a_addr = 32'h10; a_size = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_error !== 1'b1 || a_ready !== 1'b0 || a_stall !== 1'b0) begin
        errors++; $display("FAIL both_high cyc%0d: got err=%b rdy=%b stall=%b expected 1 0 0", i, a_error, a_ready, a_stall);
      end
      @(negedge clk);
    end
    a_read = 0; a_write = 0;
    #1;
    checks++; if (a_error !== 1'b0 || a_ready !== 1'b0) begin errors++; $display("FAIL both_high_release: got err=%b rdy=%b expected 0 0", a_error, a_ready); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int s; bit ok;
    logic [31:0] vals [3];
    int idx;
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      access(1, 1, 32'(i * 4), vals[i], 2'b10, 0, d, e, s, ok);
      checks++; if (!ok || s != 1) begin errors++; $display("FAIL ws0_store%0d: got stalls %0d expected 1", i, s); end
    end
    idx = 0;
    b_read = 1; b_addr = 32'h0; b_size = 2'b10;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (b_stall !== ((c % 2) == 0) || b_ready !== ((c % 2) == 1)) begin
        errors++; $display("FAIL b2b cyc%0d: got stall=%b ready=%b expected %0d %0d", c, b_stall, b_ready, (c % 2) == 0, (c % 2) == 1);
      end
      if (b_ready === 1'b1 && idx < 3) begin
        checks++; if (b_dout !== vals[idx]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", idx, b_dout, vals[idx]); end
        $display("b2b load %0d data=%h", idx, b_dout);
        idx++;
        b_addr = 32'(idx * 4);
      end
      @(negedge clk);
    end
    b_read = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int s; bit ok;
    access(0, 1, 32'h40, 32'h12345678, 2'b10, 0, d, e, s, ok);
    a_write = 1; a_addr = 32'h40; a_din = 32'h00000055; a_size = 2'b10;
    @(posedge clk); #1;
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL busy_before_reset: got %b expected 1", a_stall); end
    n_reset = 0; #1;
    checks++; if (a_ready !== 0 || a_error !== 0 || a_stall !== 0 || a_dout !== 32'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got rdy=%b err=%b stall=%b dout=%h expected all 0", a_ready, a_error, a_stall, a_dout);
    end
    @(negedge clk);
    a_write = 0;
    @(negedge clk);
    n_reset = 1;
    @(negedge clk);
    access(0, 0, 32'h40, 32'h0, 2'b10, 0, d, e, s, ok);
    checks++; if (!ok || d !== 32'h12345678) begin errors++; $display("FAIL aborted_write: got %h expected 12345678", d); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_store();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
